// File: rtl/load_store_unit_if.sv
// Pipeline request/response channel plus the word-addressed data-memory port of the load/store unit.
// The LSU takes the slave side; the pipeline and memory together take the master side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [31:0] data_read;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_data,
        output mem_read, mem_write, address, data_write,
        input  data_read
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_data,
        input  mem_read, mem_write, address, data_write,
        output data_read
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer with sub-word RMW stores; response 1 (error), 2 (load/word store) or 3 (sub-word store) cycles after accept.
// Backpressure: req_ready is low from accept until the response cycle has passed; one transaction in flight.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, ST_W, RMW_RD, RMW_WR, RESP} state_t;

    typedef struct packed {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    req_t        req_q;
    logic [31:0] merged_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;

    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
        logic misal;
        case (size)
            2'b00:   misal = 1'b0;
            2'b01:   misal = addr[0];
            2'b10:   misal = |addr[1:0];
            default: misal = 1'b1;
        endcase
        return misal || (addr[31:2] >= WORD_LIMIT);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{~uns & b[7]}}, b};
            2'b01:   return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        if (size == 2'b00)
            r[{off, 3'b000} +: 8] = wdata[7:0];
        else
            r[{off[1], 4'b0000} +: 16] = wdata[15:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_q        <= '0;
            merged_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= '{store: bus.req_store, size: bus.req_size, uns: bus.req_unsigned,
                                   addr: bus.req_addr, wdata: bus.req_wdata};
                        if (req_bad(bus.req_size, bus.req_addr)) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else if (!bus.req_store) begin
                            state <= LOAD;
                        end else if (bus.req_size == 2'b10) begin
                            state <= ST_W;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_data_q  <= load_extract(bus.data_read, req_q.size, req_q.addr[1:0], req_q.uns);
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                ST_W, RMW_WR: begin
                    resp_data_q  <= '0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RMW_RD: begin
                    merged_q <= lane_merge(bus.data_read, req_q.wdata, req_q.size, req_q.addr[1:0]);
                    state    <= RMW_WR;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes are gated by reset directly so an aborted write never reaches the negedge.
    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = '0;
        bus.data_write = '0;
        if (!reset) begin
            bus.mem_read  = (state == LOAD) || (state == RMW_RD);
            bus.mem_write = (state == ST_W) || (state == RMW_WR);
            bus.address   = {req_q.addr[31:2], 2'b00};
            if (state == ST_W)
                bus.data_write = req_q.wdata;
            else if (state == RMW_WR)
                bus.data_write = merged_q;
        end
    end

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_data  = resp_data_q;

endmodule
